// File: rtl/sm_dbg_responder_pkg.sv
// Shared encodings for the debug read responder: target spaces, FSM states,
// legal read-latency range and the wrapping word-address increment.
package sm_dbg_responder_pkg;

   localparam logic SPACE_REG = 1'b0;
   localparam logic SPACE_RAM = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Word addresses are 5 bits, so 31 naturally rolls over to 0.
   function automatic logic [4:0] addr_inc(input logic [4:0] a);
      return a + 5'd1;
   endfunction

endpackage

// File: rtl/sm_dbg_responder.sv
// Read-only debug responder: walks a burst of words out of the CPU register
// file/PC or the data RAM and returns them one at a time over a valid/ready link.
module sm_dbg_responder
   import sm_dbg_responder_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_space,
   input  logic [4:0]  req_addr,
   input  logic [3:0]  req_len,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic [4:0]  ramAddrB,
   input  logic [31:0] ramDataB,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_addr,
   output logic        resp_last
);

   localparam int RD_LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
   // The wait counter only has to distinguish the first and second wait cycle.
   localparam logic WAIT_LAST = (RD_LAT_C == RD_LAT_MAX);

   state_e      state_q;
   logic        space_q;
   logic [4:0]  addr_q;
   logic [3:0]  remaining_q;
   logic        wait_cnt_q;
   logic [4:0]  reg_addr_q;
   logic [4:0]  ram_addr_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic [4:0]  resp_addr_q;
   logic        resp_last_q;

   logic [4:0]  addr_d;
   logic [3:0]  remaining_d;

   assign addr_d      = addr_inc(addr_q);
   assign remaining_d = remaining_q - 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         space_q      <= SPACE_REG;
         addr_q       <= '0;
         remaining_q  <= '0;
         wait_cnt_q   <= 1'b0;
         reg_addr_q   <= '0;
         ram_addr_q   <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_addr_q  <= '0;
         resp_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  space_q     <= req_space;
                  addr_q      <= req_addr;
                  remaining_q <= req_len;
                  wait_cnt_q  <= 1'b0;
                  if (req_space == SPACE_RAM) ram_addr_q <= req_addr;
                  else                        reg_addr_q <= req_addr;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == WAIT_LAST) begin
                  resp_data_q  <= (space_q == SPACE_RAM) ? ramDataB : regData;
                  resp_addr_q  <= addr_q;
                  resp_last_q  <= (remaining_q == 4'd0);
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_last_q  <= 1'b0;
                  if (remaining_q == 4'd0) begin
                     req_ready_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end else begin
                     addr_q      <= addr_d;
                     remaining_q <= remaining_d;
                     wait_cnt_q  <= 1'b0;
                     if (space_q == SPACE_RAM) ram_addr_q <= addr_d;
                     else                      reg_addr_q <= addr_d;
                     state_q     <= ST_WAIT;
                  end
               end
            end
            default: begin
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_last_q  <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign regAddr    = reg_addr_q;
   assign ramAddrB   = ram_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_addr  = resp_addr_q;
   assign resp_last  = resp_last_q;

endmodule

// File: tb/tb_sm_dbg_responder.sv
// Scoreboard bench for sm_dbg_responder: one instance with RD_LAT=1 on
// combinational sources, one with RD_LAT=2 on a synchronous RAM model.
module tb_sm_dbg_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_space = 1'b0;
   logic [4:0]  req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        resp_ready = 1'b0;

   logic [31:0] rf  [32];
   logic [31:0] ram [32];

   logic        req_ready1, resp_valid1, resp_last1;
   logic [4:0]  regAddr1, ramAddrB1, resp_addr1;
   logic [31:0] resp_data1;
   logic        req_ready2, resp_valid2, resp_last2;
   logic [4:0]  regAddr2, ramAddrB2, resp_addr2;
   logic [31:0] resp_data2;
   logic [31:0] ram_q2;

   logic        req_ready_m, resp_valid_m, resp_last_m;
   logic [4:0]  resp_addr_m, regAddr_m, ramAddrB_m;
   logic [31:0] resp_data_m;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        last;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) ram_q2 <= ram[ramAddrB2];

   sm_dbg_responder #(.RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & ~sel), .req_ready(req_ready1),
      .req_space(req_space), .req_addr(req_addr), .req_len(req_len),
      .regAddr(regAddr1), .regData(rf[regAddr1]),
      .ramAddrB(ramAddrB1), .ramDataB(ram[ramAddrB1]),
      .resp_valid(resp_valid1), .resp_ready(resp_ready & ~sel),
      .resp_data(resp_data1), .resp_addr(resp_addr1), .resp_last(resp_last1)
   );

   sm_dbg_responder #(.RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & sel), .req_ready(req_ready2),
      .req_space(req_space), .req_addr(req_addr), .req_len(req_len),
      .regAddr(regAddr2), .regData(rf[regAddr2]),
      .ramAddrB(ramAddrB2), .ramDataB(ram_q2),
      .resp_valid(resp_valid2), .resp_ready(resp_ready & sel),
      .resp_data(resp_data2), .resp_addr(resp_addr2), .resp_last(resp_last2)
   );

   assign req_ready_m  = sel ? req_ready2  : req_ready1;
   assign resp_valid_m = sel ? resp_valid2 : resp_valid1;
   assign resp_last_m  = sel ? resp_last2  : resp_last1;
   assign resp_addr_m  = sel ? resp_addr2  : resp_addr1;
   assign resp_data_m  = sel ? resp_data2  : resp_data1;
   assign regAddr_m    = sel ? regAddr2    : regAddr1;
   assign ramAddrB_m   = sel ? ramAddrB2   : ramAddrB1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_req_ready", {31'd0, req_ready_m}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid_m}, 32'd0);
      chk("rst_resp_last", {31'd0, resp_last_m}, 32'd0);
      chk("rst_resp_data", resp_data_m, 32'd0);
      chk("rst_resp_addr", {27'd0, resp_addr_m}, 32'd0);
      chk("rst_regAddr", {27'd0, regAddr_m}, 32'd0);
      chk("rst_ramAddrB", {27'd0, ramAddrB_m}, 32'd0);
   endtask

   // exp_cycles > 0: ready held high, check first/last handshake edge numbers.
   // abort_word >= 0: assert rst while that word is being presented.
   task automatic run_burst(input logic s, input logic [4:0] a, input logic [3:0] len,
                            input bit rnd, input int exp_cycles, input int abort_word,
                            input bit noise);
      int edges, words, first_edge, last_edge;
      logic rdy;
      logic [4:0] aw;
      exp_t e;
      @(negedge clk);
      edges = 0;
      while (!req_ready_m && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      chk("req_ready_idle", {31'd0, req_ready_m}, 32'd1);
      req_valid = 1'b1;
      req_space = s;
      req_addr  = a;
      req_len   = len;
      for (int i = 0; i <= int'(len); i++) begin
         aw = a + 5'(i);
         e.data = s ? ram[aw] : rf[aw];
         e.addr = aw;
         e.last = (i == int'(len));
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = noise;
      req_space = ~s;
      req_addr  = ~a;
      req_len   = 4'hF;
      edges = 0; words = 0; first_edge = 0; last_edge = 0;
      while (sb.size() > 0 && edges < 400) begin
         @(negedge clk);
         if (edges == 0) chk("req_ready_busy", {31'd0, req_ready_m}, 32'd0);
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (resp_valid_m) begin
            chk("resp_data", resp_data_m, sb[0].data);
            chk("resp_addr", {27'd0, resp_addr_m}, {27'd0, sb[0].addr});
            chk("resp_last", {31'd0, resp_last_m}, {31'd0, sb[0].last});
            if (abort_word == words) begin
               rst = 1'b1;
               #1;
               chk("abort_valid", {31'd0, resp_valid_m}, 32'd0);
               sb.delete();
               req_valid = 1'b0;
               resp_ready = 1'b0;
               $display("abort burst at word %0d", words);
               return;
            end
         end
         req_valid = noise && !(resp_valid_m && rdy && sb[0].last);
         resp_ready = rdy;
         if (resp_valid_m && rdy) begin
            if (words == 0) first_edge = edges + 1;
            last_edge = edges + 1;
            $display("word %0d addr=%0d data=0x%08h last=%0b", words, resp_addr_m,
                     resp_data_m, resp_last_m);
            void'(sb.pop_front());
            words++;
         end
         @(posedge clk);
         edges++;
      end
      #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("burst_words", 32'(words), 32'(int'(len) + 1));
      if (exp_cycles > 0) begin
         chk("first_word_edge", 32'(first_edge), 32'(exp_cycles / (int'(len) + 1)));
         chk("burst_cycles", 32'(last_edge), 32'(exp_cycles));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i]  = 32'hA000 + 32'(i);
         ram[i] = 32'(i) + 32'd100;
      end
      rf[0] = 32'd7;
      rf[2] = 32'h1234;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state();

      run_burst(1'b0, 5'd0, 4'd0, 1'b0, 2, -1, 1'b0);
      run_burst(1'b0, 5'd2, 4'd0, 1'b0, 2, -1, 1'b0);
      run_burst(1'b1, 5'd0, 4'd15, 1'b0, 32, -1, 1'b0);
      chk("reg_addr_hold", {27'd0, regAddr_m}, 32'd2);
      run_burst(1'b0, 5'd30, 4'd3, 1'b1, 0, -1, 1'b1);
      chk("ram_addr_hold", {27'd0, ramAddrB_m}, 32'd15);
      run_burst(1'b1, 5'd31, 4'd15, 1'b0, 32, -1, 1'b0);

      run_burst(1'b1, 5'd4, 4'd7, 1'b0, 0, 2, 1'b0);
      repeat (2) @(negedge clk);
      chk("abort_hold_valid", {31'd0, resp_valid_m}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state();
      run_burst(1'b0, 5'd5, 4'd0, 1'b0, 2, -1, 1'b0);

      sel = 1'b1;
      run_burst(1'b1, 5'd8, 4'd7, 1'b0, 24, -1, 1'b0);
      run_burst(1'b1, 5'd29, 4'd3, 1'b1, 0, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
